alarm_ringer: RTL and testbench
===============================

Name: alarm_ringer

Overview:
- Consumes the alarm comparator's `linerow` match level and drives the buzzer.
- Turns the level, which stays high for a whole matching minute, into one alarm event.
- Runs a timed ring with a gated beep pattern, snooze with a limited repeat count, a stop key and auto-timeout.
- Sits between the alarm comparator and the board buzzer pin.

Parameters:
- CLK_DIV, 50_000_000: clk cycles per one-second tick; must be at least 4 and even.
- TONE_DIV, 12_500: clk cycles per half period of the buzzer tone.
- RING_SEC, 60: seconds of ringing before auto-stop.
- SNOOZE_SEC, 300: seconds of silence before re-ring.
- MAX_SNOOZE, 3: snoozes allowed per alarm event.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alarm_en  in  1  alarm armed switch; 0 silences and disarms immediately.
- linerow  in  1  alarm match level from the comparator, synchronous to clk.
- key_stop_n  in  1  stop key, active-low, raw from pin.
- key_snooze_n  in  1  snooze key, active-low, raw from pin.
- beep  out  1  buzzer drive.
- ringing  out  1  high while state is RING.
- snoozing  out  1  high while state is SNOOZE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; beep=0, ringing=0, snoozing=0.
  - Prescaler, second counter, tone counter, tone flop and snooze count all 0.
  - linerow_d=0; key sync flops=1.
- Keys:
  - Each key passes through 3 flops (sync1, sync2, prev); press = prev & ~sync2.
  - If a key is first sampled low at edge k, its action takes effect on the state at edge k+2.
  - One press per falling level; holding the key gives no repeat.
- Match edge: linerow_d is registered linerow; hit = linerow & ~linerow_d. Entering RING happens at the same edge the hit is sampled.
- Timebase:
  - Prescaler counts 0..CLK_DIV-1; sec_tick pulses when it equals CLK_DIV-1.
  - Prescaler and second counter clear on every state entry, so RING lasts exactly RING_SEC*CLK_DIV cycles and SNOOZE exactly SNOOZE_SEC*CLK_DIV cycles.
- FSM:
  - IDLE: if alarm_en & hit, go to RING; snooze count=0.
  - RING: stop press, go to DONE. Else snooze press with count<MAX_SNOOZE, go to SNOOZE and count+1. Else RING_SEC elapsed, go to DONE.
  - SNOOZE: stop press, go to DONE. Else SNOOZE_SEC elapsed, go to RING. Snooze presses are ignored.
  - DONE: wait for linerow=0, then go to IDLE. This blocks re-triggering within the same matching minute.
- alarm_en=0 forces IDLE from any state on the next edge, with beep=0 that cycle. It overrides all other events.
- Simultaneous events:
  - Stop and snooze on the same cycle: stop wins.
  - Stop on the same cycle as ring timeout: DONE either way.
  - Snooze when count=MAX_SNOOZE: ignored; ringing continues.
- Snooze re-ring does not require linerow; it rings even if the matching minute has passed.
- Outputs: ringing and snoozing are decoded from the state register (registered, no glitches).
- Beep:
  - The tone flop toggles every TONE_DIV cycles while in RING and clears on RING entry.
  - beep = RING & tone & (prescaler < CLK_DIV/2), i.e. 0.5 s on / 0.5 s off bursts starting with "on".
  - beep=0 in all other states.
- Reset mid-ring: outputs drop asynchronously. After release, a still-high linerow does not ring, because linerow_d starts at 0 but IDLE requires a rising edge: the first cycle sees linerow_d=0 and rings. Therefore linerow_d resets to 1 instead (overrides the 0 listed under Reset). This is decided: no ring after reset until linerow falls and rises.

Test Plan (CLK_DIV=10, TONE_DIV=2, RING_SEC=3, SNOOZE_SEC=2, MAX_SNOOZE=2):
- Basic ring:
  - Stimulus: alarm_en=1; linerow rises at edge 100 and is held.
  - Response: ringing=1 from edge 100 to edge 130. beep toggles every 2 cycles during prescaler 0..4, is 0 during 5..9. Then state DONE, ringing=0; state goes to IDLE one edge after linerow falls.
- Stop:
  - Stimulus: during RING, key_stop_n low first sampled at edge k.
  - Response: ringing=0 and beep=0 from edge k+2. Holding linerow high gives no re-ring.
- Snooze limit:
  - Stimulus: press snooze 3 times, once in each RING period.
  - Response: first two presses give snoozing=1 for exactly 20 cycles, then RING. Third press is ignored; auto-stop after 30 cycles.
- Priority:
  - Stimulus: stop and snooze pressed on the same cycle in RING.
  - Response: DONE, snoozing never asserts.
- Disarm:
  - Stimulus: alarm_en=0 mid-SNOOZE.
  - Response: IDLE next edge, all outputs 0. Re-enabling with linerow still high gives no ring.
- Reset:
  - Stimulus: rst_n low mid-RING, released with linerow high.
  - Response: outputs 0 immediately; no ring until linerow goes 0 then 1.

Source files
------------

// File: rtl/alarm_ringer.sv
// Alarm buzzer controller: turns the comparator's match level into one ring event
// with a gated beep, snooze with a repeat limit, a stop key and auto-timeout.
module alarm_ringer #(
  parameter int unsigned CLK_DIV    = 50_000_000,
  parameter int unsigned TONE_DIV   = 12_500,
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_SEC = 300,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic alarm_en,
  input  logic linerow,
  input  logic key_stop_n,
  input  logic key_snooze_n,
  output logic beep,
  output logic ringing,
  output logic snoozing
);

  localparam int unsigned SEC_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
  localparam int unsigned PW = $clog2(CLK_DIV);
  localparam int unsigned SW = $clog2(SEC_MAX + 1);
  localparam int unsigned TW = $clog2(TONE_DIV + 1);
  localparam int unsigned CW = $clog2(MAX_SNOOZE + 2);

  localparam logic [PW-1:0] PRESC_LAST  = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] BEEP_HALF   = PW'(CLK_DIV / 2);
  localparam logic [SW-1:0] RING_LAST   = SW'(RING_SEC - 1);
  localparam logic [SW-1:0] SNOOZE_LAST = SW'(SNOOZE_SEC - 1);
  localparam logic [TW-1:0] TONE_LAST   = TW'(TONE_DIV - 1);
  localparam logic [CW-1:0] SNZ_LIMIT   = CW'(MAX_SNOOZE);

  typedef enum logic [1:0] {S_IDLE, S_RING, S_SNOOZE, S_DONE} state_t;

  state_t          r_state, w_nxt;
  logic [PW-1:0]   r_presc, w_presc_nxt;
  logic [SW-1:0]   r_sec, w_sec_nxt;
  logic [TW-1:0]   r_tone_cnt, w_tone_cnt_nxt;
  logic            r_tone, w_tone_nxt;
  logic [CW-1:0]   r_snz_cnt, w_snz_cnt_nxt;
  logic            r_linerow_d;
  logic            r_stop_s1, r_stop_s2, r_stop_prev;
  logic            r_snz_s1, r_snz_s2, r_snz_prev;
  logic            r_beep, r_ringing, r_snoozing;
  logic            w_hit, w_stop, w_snz, w_tick, w_ring_to, w_snz_to, w_enter, w_beep_nxt;

  always_comb begin
    w_hit     = linerow & ~r_linerow_d;
    w_stop    = r_stop_prev & ~r_stop_s2;
    w_snz     = r_snz_prev & ~r_snz_s2;
    w_tick    = (r_presc == PRESC_LAST);
    w_ring_to = w_tick && (r_sec == RING_LAST);
    w_snz_to  = w_tick && (r_sec == SNOOZE_LAST);

    w_nxt         = r_state;
    w_snz_cnt_nxt = r_snz_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_hit) begin
          w_nxt         = S_RING;
          w_snz_cnt_nxt = '0;
        end
      end
      S_RING: begin
        if (w_stop) begin
          w_nxt = S_DONE;
        end else if (w_snz && (r_snz_cnt < SNZ_LIMIT)) begin
          w_nxt         = S_SNOOZE;
          w_snz_cnt_nxt = r_snz_cnt + 1'b1;
        end else if (w_ring_to) begin
          w_nxt = S_DONE;
        end
      end
      S_SNOOZE: begin
        if (w_stop)        w_nxt = S_DONE;
        else if (w_snz_to) w_nxt = S_RING;
      end
      S_DONE: begin
        if (!linerow) w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
    if (!alarm_en) w_nxt = S_IDLE;

    // Timebase restarts on every state change so each phase has an exact length.
    w_enter = (w_nxt != r_state);
    if (w_enter) begin
      w_presc_nxt = '0;
      w_sec_nxt   = '0;
    end else if (w_tick) begin
      w_presc_nxt = '0;
      w_sec_nxt   = ((r_state == S_RING) || (r_state == S_SNOOZE)) ? r_sec + 1'b1 : r_sec;
    end else begin
      w_presc_nxt = r_presc + 1'b1;
      w_sec_nxt   = r_sec;
    end

    if ((r_state == S_RING) && (w_nxt == S_RING)) begin
      if (r_tone_cnt == TONE_LAST) begin
        w_tone_cnt_nxt = '0;
        w_tone_nxt     = ~r_tone;
      end else begin
        w_tone_cnt_nxt = r_tone_cnt + 1'b1;
        w_tone_nxt     = r_tone;
      end
    end else begin
      w_tone_cnt_nxt = '0;
      w_tone_nxt     = 1'b0;
    end

    // Beep is registered from next-state values, equal to RING & tone & first half-second.
    w_beep_nxt = (w_nxt == S_RING) && w_tone_nxt && (w_presc_nxt < BEEP_HALF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_presc     <= '0;
      r_sec       <= '0;
      r_tone_cnt  <= '0;
      r_tone      <= 1'b0;
      r_snz_cnt   <= '0;
      r_linerow_d <= 1'b1;
      r_stop_s1   <= 1'b1;
      r_stop_s2   <= 1'b1;
      r_stop_prev <= 1'b1;
      r_snz_s1    <= 1'b1;
      r_snz_s2    <= 1'b1;
      r_snz_prev  <= 1'b1;
      r_beep      <= 1'b0;
      r_ringing   <= 1'b0;
      r_snoozing  <= 1'b0;
    end else begin
      r_state     <= w_nxt;
      r_presc     <= w_presc_nxt;
      r_sec       <= w_sec_nxt;
      r_tone_cnt  <= w_tone_cnt_nxt;
      r_tone      <= w_tone_nxt;
      r_snz_cnt   <= w_snz_cnt_nxt;
      r_linerow_d <= linerow;
      r_stop_s1   <= key_stop_n;
      r_stop_s2   <= r_stop_s1;
      r_stop_prev <= r_stop_s2;
      r_snz_s1    <= key_snooze_n;
      r_snz_s2    <= r_snz_s1;
      r_snz_prev  <= r_snz_s2;
      r_beep      <= w_beep_nxt;
      r_ringing   <= (w_nxt == S_RING);
      r_snoozing  <= (w_nxt == S_SNOOZE);
    end
  end

  assign beep     = r_beep;
  assign ringing  = r_ringing;
  assign snoozing = r_snoozing;

endmodule

// File: tb/tb_alarm_ringer.sv
// Bench for alarm_ringer: directed scenarios then random keys/linerow, checked
// every cycle against a model that tracks elapsed time per phase.
module tb_alarm_ringer;

  localparam int CLK_DIV    = 10;
  localparam int TONE_DIV   = 2;
  localparam int RING_SEC   = 3;
  localparam int SNOOZE_SEC = 2;
  localparam int MAX_SNOOZE = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic alarm_en = 1'b0;
  logic linerow = 1'b0;
  logic key_stop_n = 1'b1;
  logic key_snooze_n = 1'b1;
  logic beep, ringing, snoozing;

  alarm_ringer #(
    .CLK_DIV   (CLK_DIV),
    .TONE_DIV  (TONE_DIV),
    .RING_SEC  (RING_SEC),
    .SNOOZE_SEC(SNOOZE_SEC),
    .MAX_SNOOZE(MAX_SNOOZE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alarm_en    (alarm_en),
    .linerow     (linerow),
    .key_stop_n  (key_stop_n),
    .key_snooze_n(key_snooze_n),
    .beep        (beep),
    .ringing     (ringing),
    .snoozing    (snoozing)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: mode 0 idle, 1 ring, 2 snooze, 3 done; elapsed = cycles since phase entry.
  int   m_mode, m_elapsed, m_used;
  logic m_lr_prev;
  logic m_st_h1, m_st_h2, m_st_h3;
  logic m_sn_h1, m_sn_h2, m_sn_h3;

  task automatic model_reset();
    m_mode = 0; m_elapsed = 0; m_used = 0; m_lr_prev = 1'b1;
    m_st_h1 = 1'b1; m_st_h2 = 1'b1; m_st_h3 = 1'b1;
    m_sn_h1 = 1'b1; m_sn_h2 = 1'b1; m_sn_h3 = 1'b1;
  endtask

  task automatic model_edge();
    logic stop_p, snz_p, hit;
    int nm;
    stop_p = m_st_h3 & ~m_st_h2;
    snz_p  = m_sn_h3 & ~m_sn_h2;
    hit    = linerow & ~m_lr_prev;
    nm = m_mode;
    case (m_mode)
      0: if (hit) begin nm = 1; m_used = 0; end
      1: begin
        if (stop_p) nm = 3;
        else if (snz_p && m_used < MAX_SNOOZE) begin nm = 2; m_used++; end
        else if (m_elapsed == RING_SEC * CLK_DIV - 1) nm = 3;
      end
      2: begin
        if (stop_p) nm = 3;
        else if (m_elapsed == SNOOZE_SEC * CLK_DIV - 1) nm = 1;
      end
      default: if (!linerow) nm = 0;
    endcase
    if (!alarm_en) nm = 0;
    m_elapsed = (nm != m_mode) ? 0 : m_elapsed + 1;
    m_mode = nm;
    m_lr_prev = linerow;
    m_st_h3 = m_st_h2; m_st_h2 = m_st_h1; m_st_h1 = key_stop_n;
    m_sn_h3 = m_sn_h2; m_sn_h2 = m_sn_h1; m_sn_h1 = key_snooze_n;
  endtask

  task automatic check(input string tag, input logic act, input logic exp);
    n_vec++;
    assert (act === exp) else begin
      n_err++;
      $error("FAIL %s at %0t: observed=%b expected=%b", tag, $time, act, exp);
    end
  endtask

  task automatic check_outputs();
    logic e_ring, e_snz, e_beep;
    e_ring = (m_mode == 1);
    e_snz  = (m_mode == 2);
    e_beep = e_ring && ((m_elapsed % CLK_DIV) < CLK_DIV / 2)
                    && (((m_elapsed / TONE_DIV) % 2) == 1);
    check("ringing", ringing, e_ring);
    check("snoozing", snoozing, e_snz);
    check("beep", beep, e_beep);
  endtask

  task automatic step(input logic en, input logic lr, input logic st_n, input logic sn_n);
    alarm_en = en; linerow = lr; key_stop_n = st_n; key_snooze_n = sn_n;
    @(posedge clk);
    model_edge();
    #1 check_outputs();
  endtask

  task automatic idle(input int n, input logic en, input logic lr);
    for (int i = 0; i < n; i++) step(en, lr, 1'b1, 1'b1);
  endtask

  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_ringing", ringing, 1'b0);
    check("rst_snoozing", snoozing, 1'b0);
    check("rst_beep", beep, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    model_edge();
    #1 check_outputs();
  endtask

  initial begin
    model_reset();
    #1;
    check("por_ringing", ringing, 1'b0);
    check("por_snoozing", snoozing, 1'b0);
    check("por_beep", beep, 1'b0);
    #20 rst_n = 1'b1;
    @(posedge clk); model_edge(); #1 check_outputs();

    // Basic ring with auto-timeout, then DONE until linerow falls.
    idle(5, 1'b1, 1'b0);
    idle(45, 1'b1, 1'b1);
    idle(3, 1'b1, 1'b0);

    // Stop key while ringing; held linerow must not re-ring.
    idle(8, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    idle(10, 1'b1, 1'b1);
    idle(3, 1'b1, 1'b0);

    // Snooze limit: two accepted, third ignored, then auto-stop.
    idle(5, 1'b1, 1'b1);
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
      idle(25, 1'b1, 1'b1);
    end
    idle(20, 1'b1, 1'b0);

    // Stop and snooze together: stop wins.
    idle(5, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    idle(10, 1'b1, 1'b1);
    idle(3, 1'b1, 1'b0);

    // Disarm mid-snooze, re-enable with linerow high.
    idle(4, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    idle(6, 1'b1, 1'b1);
    idle(1, 1'b0, 1'b1);
    idle(10, 1'b1, 1'b1);
    idle(3, 1'b1, 1'b0);

    // Reset mid-ring with linerow held high.
    idle(6, 1'b1, 1'b1);
    reset_pulse();
    idle(10, 1'b1, 1'b1);
    idle(2, 1'b1, 1'b0);
    idle(12, 1'b1, 1'b1);

    // Random phase.
    for (int i = 0; i < 3000; i++) begin
      logic en, lr, st, sn;
      en = ($urandom_range(0, 99) != 0);
      lr = ($urandom_range(0, 39) == 0) ? ~linerow : linerow;
      st = ($urandom_range(0, 29) == 0) ? 1'b0 : (key_stop_n | ($urandom_range(0, 2) == 0));
      sn = ($urandom_range(0, 9) == 0) ? 1'b0 : (key_snooze_n | ($urandom_range(0, 2) == 0));
      step(en, lr, st, sn);
      if (i == 1500) reset_pulse();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
